mem_writer: RTL and testbench
=============================

# mem_writer

Sequential memory loader that writes a burst of bytes into the 256x8 display RAM. A byte stream arrives over a valid/ready handshake and is written at consecutive addresses from a programmable base. It is the write-side counterpart of the step-driven address sequencer that reads the RAM out to the byte mux and displays. It sits between the input source (switches or serial byte receiver) and the RAM write port.

## Interface
- ADDR_W, 8, RAM address width; address space 2**ADDR_W
- DATA_W, 8, byte width
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle request to begin a load session; honoured only in IDLE
- base_addr  in  ADDR_W  first write address, sampled with start
- length  in  ADDR_W+1  bytes to write, 0..2**ADDR_W, sampled with start
- in_valid  in  1  in_data holds a byte
- in_data  in  DATA_W  byte to write
- in_ready  out  1  block accepts in_data this cycle
- wr_en  out  1  RAM write strobe, one cycle per byte
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  DATA_W  RAM write data
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse at session end
- count  out  ADDR_W+1  bytes written in current or last session
- checksum  out  DATA_W  running byte sum (see Configuration)

## Operation
- States: IDLE, LOAD, DONE; encoding 0, 1, 2.
- IDLE:
  - start with length != 0 -> LOAD; ptr <= base_addr, remaining <= length, count <= 0.
  - start with length == 0 -> DONE; no writes; count <= 0.
- LOAD:
  - in_ready = 1. Acceptance = in_valid & in_ready.
  - On acceptance: wr_en <= 1, wr_addr <= ptr, wr_data <= in_data, ptr <= ptr + 1, remaining <= remaining - 1, count <= count + 1.
  - If the accepted byte is the last one (remaining == 1) -> DONE.
  - Without acceptance: wr_en <= 0; stay in LOAD indefinitely. There is no timeout.
- DONE: done = 1 for exactly one cycle, then IDLE. count holds until the next start.
- ptr is ADDR_W wide and wraps modulo 2**ADDR_W; e.g. base 8'hFE, length 4 writes FE, FF, 00, 01.
- length = 2**ADDR_W writes every location exactly once.
- start is ignored while busy. in_valid outside LOAD is ignored and nothing is written.
- in_ready is decoded from the registered state only and has no combinational path from in_valid.

## Timing
- Reset values: state IDLE, in_ready 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, count 0, checksum 0.
- start at cycle N -> busy and in_ready high at N+1.
- Byte accepted at cycle M -> wr_en/wr_addr/wr_data valid at M+1 for one cycle. Write latency is 1.
- Back-to-back in_valid gives one write per cycle; throughput is 1 byte/clock.
- Last byte accepted at M -> final wr_en and done both at M+1; busy low at M+2.
- Reset asserted mid-session takes effect immediately:
  - All outputs return to reset values.
  - A pending wr_en is dropped; the partial burst is not completed.
  - After reset release, the first start is serviced normally.

## Configuration
- Macro MEM_WRITER_CHECKSUM_EN.
- Defined:
  - checksum is cleared on an accepted start.
  - On each acceptance, checksum <= checksum + in_data, modulo 2**DATA_W.
  - Its value is final in the cycle done is high, and it holds until the next start.
- Undefined: checksum is tied to 0 and no adder is built.

## Structure
- Package mem_writer_pkg holds:
  - State constants ST_IDLE, ST_LOAD, ST_DONE and the 2-bit state width.
  - Default ADDR_W/DATA_W values.
- Sub-module mem_writer_ptr: loadable ADDR_W up-counter.
  - Inputs: clock, reset, load, load_val, inc.
  - Output: ptr, wrapping modulo 2**ADDR_W.
  - Instantiated once for the write pointer.
- The top level holds the FSM, the remaining/count counters, the output registers and the optional checksum.

## Test plan
- Reset then start, base 8'h10, length 3, bytes AA, BB, CC streamed continuously -> writes 10:AA, 11:BB, 12:CC on consecutive cycles; done pulses with the last write; count 3; checksum 8'h31 with macro defined, 0 without.
- Wrap: base 8'hFE, length 4, bytes 01..04 -> addresses FE, FF, 00, 01; count 4.
- Gapped in_valid (1 high, 2 low, repeating), length 2 -> exactly 2 wr_en pulses, each one cycle after its acceptance; no writes in gap cycles.
- start with length 0 -> no wr_en; done pulse at N+1; busy high only in the DONE cycle; count 0.
- start pulsed again during LOAD, and in_valid asserted in IDLE -> both ignored; session address sequence unchanged; no extra writes.
- Reset asserted after 2 of 5 bytes -> wr_en low immediately; all outputs at reset values; a subsequent start with base 0, length 1 completes normally.

Source files
------------

// File: rtl/mem_writer_pkg.sv
// Shared constants for the display-RAM burst loader: FSM state encoding
// and default address/data widths.
package mem_writer_pkg;

    localparam int STATE_W    = 2;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_writer_ptr.sv
// Loadable write-address up-counter. The pointer wraps modulo 2**ADDR_W,
// so a burst that runs off the top of the RAM continues at address 0.
module mem_writer_ptr
    import mem_writer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    // Load takes priority over increment; natural overflow gives the wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= ptr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/mem_writer.sv
// Burst loader for the 256x8 display RAM: accepts a byte stream over a
// valid/ready handshake and writes it at consecutive addresses from a
// programmable base, one registered write per accepted byte.
// Optional feature: define MEM_WRITER_CHECKSUM_EN to build the running
// byte-sum output; otherwise checksum is tied to zero.
module mem_writer
    import mem_writer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic [DATA_W-1:0] checksum
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W-1:0] ptr;
    logic              start_go;
    logic              accept;
    logic              last_byte;

    // start is only honoured in IDLE; bytes are only taken in LOAD.
    assign start_go  = (state == ST_IDLE) && start;
    assign accept    = (state == ST_LOAD) && in_valid;
    assign last_byte = (remaining == (ADDR_W+1)'(1));

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; a zero-length start goes straight to DONE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (length == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept && last_byte) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state only, so in_ready
    // never depends combinationally on in_valid.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    mem_writer_ptr #(
        .ADDR_W (ADDR_W)
    ) u_ptr (
        .clock    (clock),
        .reset    (reset),
        .load     (start_go),
        .load_val (base_addr),
        .inc      (accept),
        .ptr      (ptr)
    );

    // Write port registers and session counters; the write strobe is the
    // acceptance delayed by one cycle, and count holds after the session.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            remaining <= '0;
            count     <= '0;
        end else begin
            wr_en <= accept;
            if (start_go) begin
                remaining <= length;
                count     <= '0;
            end else if (accept) begin
                wr_addr   <= ptr;
                wr_data   <= in_data;
                remaining <= remaining - (ADDR_W+1)'(1);
                count     <= count + (ADDR_W+1)'(1);
            end
        end
    end

`ifdef MEM_WRITER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;

    // Running modulo-2**DATA_W sum of accepted bytes, cleared on start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else if (start_go) begin
            sum <= '0;
        end else if (accept) begin
            sum <= sum + in_data;
        end
    end

    assign checksum = sum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_writer.sv
// Directed bench for mem_writer: burst writes, address wrap, gapped input,
// zero-length session, ignored start/in_valid, and mid-session reset.
module tb_mem_writer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] length;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic [8:0] count;
    logic [7:0] checksum;

    int passed = 0;
    int total  = 0;

`ifdef MEM_WRITER_CHECKSUM_EN
    localparam logic [7:0] SUM_ABC = 8'h31;
`else
    localparam logic [7:0] SUM_ABC = 8'h00;
`endif

    mem_writer dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .checksum  (checksum)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_write(input string tag, input logic [7:0] a, input logic [7:0] d, input logic dn);
        check({tag, ".wr_en"}, {31'd0, wr_en}, 32'd1);
        check({tag, ".wr_addr"}, {24'd0, wr_addr}, {24'd0, a});
        check({tag, ".wr_data"}, {24'd0, wr_data}, {24'd0, d});
        check({tag, ".done"}, {31'd0, done}, {31'd0, dn});
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, ".wr_en"}, {31'd0, wr_en}, 32'd0);
        check({tag, ".wr_addr"}, {24'd0, wr_addr}, 32'd0);
        check({tag, ".wr_data"}, {24'd0, wr_data}, 32'd0);
        check({tag, ".busy"}, {31'd0, busy}, 32'd0);
        check({tag, ".done"}, {31'd0, done}, 32'd0);
        check({tag, ".count"}, {23'd0, count}, 32'd0);
        check({tag, ".checksum"}, {24'd0, checksum}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        in_valid = 1'b0; in_data = '0;
        tick(); tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // Basic burst: base 10, AA BB CC back to back.
        start = 1'b1; base_addr = 8'h10; length = 9'd3;
        tick();
        check("b1.busy", {31'd0, busy}, 32'd1);
        check("b1.in_ready", {31'd0, in_ready}, 32'd1);
        check("b1.wr_en_idle", {31'd0, wr_en}, 32'd0);
        start = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
        tick(); check_write("b1.w0", 8'h10, 8'hAA, 1'b0);
        in_data = 8'hBB;
        tick(); check_write("b1.w1", 8'h11, 8'hBB, 1'b0);
        in_data = 8'hCC;
        tick(); check_write("b1.w2", 8'h12, 8'hCC, 1'b1);
        check("b1.busy_done", {31'd0, busy}, 32'd1);
        check("b1.count", {23'd0, count}, 32'd3);
        check("b1.checksum", {24'd0, checksum}, {24'd0, SUM_ABC});
        in_valid = 1'b0;
        tick();
        check("b1.busy_end", {31'd0, busy}, 32'd0);
        check("b1.done_end", {31'd0, done}, 32'd0);
        check("b1.wr_en_end", {31'd0, wr_en}, 32'd0);
        check("b1.count_hold", {23'd0, count}, 32'd3);
        check("b1.checksum_hold", {24'd0, checksum}, {24'd0, SUM_ABC});

        // Address wrap: base FE, length 4.
        start = 1'b1; base_addr = 8'hFE; length = 9'd4;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 8'h01;
        tick(); check_write("wrap.w0", 8'hFE, 8'h01, 1'b0);
        in_data = 8'h02;
        tick(); check_write("wrap.w1", 8'hFF, 8'h02, 1'b0);
        in_data = 8'h03;
        tick(); check_write("wrap.w2", 8'h00, 8'h03, 1'b0);
        in_data = 8'h04;
        tick(); check_write("wrap.w3", 8'h01, 8'h04, 1'b1);
        check("wrap.count", {23'd0, count}, 32'd4);
        in_valid = 1'b0;
        tick();
        check("wrap.busy_end", {31'd0, busy}, 32'd0);

        // Gapped input: valid 1,0,0,1 with length 2.
        start = 1'b1; base_addr = 8'h20; length = 9'd2;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 8'h11;
        tick(); check_write("gap.w0", 8'h20, 8'h11, 1'b0);
        in_valid = 1'b0;
        tick(); check("gap.idle1", {31'd0, wr_en}, 32'd0);
        tick(); check("gap.idle2", {31'd0, wr_en}, 32'd0);
        check("gap.in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_data = 8'h22;
        tick(); check_write("gap.w1", 8'h21, 8'h22, 1'b1);
        in_valid = 1'b0;
        tick();
        check("gap.wr_en_end", {31'd0, wr_en}, 32'd0);
        check("gap.count", {23'd0, count}, 32'd2);

        // Zero-length session.
        start = 1'b1; base_addr = 8'h33; length = 9'd0;
        tick();
        start = 1'b0;
        check("zero.done", {31'd0, done}, 32'd1);
        check("zero.busy", {31'd0, busy}, 32'd1);
        check("zero.wr_en", {31'd0, wr_en}, 32'd0);
        check("zero.in_ready", {31'd0, in_ready}, 32'd0);
        check("zero.count", {23'd0, count}, 32'd0);
        tick();
        check("zero.done_end", {31'd0, done}, 32'd0);
        check("zero.busy_end", {31'd0, busy}, 32'd0);
        check("zero.wr_en_end", {31'd0, wr_en}, 32'd0);

        // in_valid in IDLE and start during LOAD are ignored.
        in_valid = 1'b1; in_data = 8'h55;
        tick(); check("ign.idle_wr0", {31'd0, wr_en}, 32'd0);
        tick(); check("ign.idle_wr1", {31'd0, wr_en}, 32'd0);
        in_valid = 1'b0; start = 1'b1; base_addr = 8'h40; length = 9'd3;
        tick();
        in_valid = 1'b1; in_data = 8'hA1; base_addr = 8'h80; length = 9'd1;
        tick(); check_write("ign.w0", 8'h40, 8'hA1, 1'b0);
        start = 1'b0; in_data = 8'hA2;
        tick(); check_write("ign.w1", 8'h41, 8'hA2, 1'b0);
        in_data = 8'hA3;
        tick(); check_write("ign.w2", 8'h42, 8'hA3, 1'b1);
        in_data = 8'hA4;
        tick();
        check("ign.done_wr", {31'd0, wr_en}, 32'd0);
        check("ign.busy_end", {31'd0, busy}, 32'd0);
        tick();
        check("ign.idle_wr2", {31'd0, wr_en}, 32'd0);
        check("ign.count", {23'd0, count}, 32'd3);
        in_valid = 1'b0;

        // Reset after 2 of 5 bytes, then a fresh single-byte session.
        start = 1'b1; base_addr = 8'h60; length = 9'd5;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 8'h01;
        tick(); check_write("rst.w0", 8'h60, 8'h01, 1'b0);
        in_data = 8'h02;
        tick(); check_write("rst.w1", 8'h61, 8'h02, 1'b0);
        reset = 1'b1;
        #1;
        check_idle_outputs("rst.async");
        tick();
        check_idle_outputs("rst.held");
        reset = 1'b0; in_valid = 1'b0;
        tick();
        check("rst.stay_idle", {31'd0, wr_en}, 32'd0);
        start = 1'b1; base_addr = 8'h00; length = 9'd1;
        tick();
        check("rst.restart_busy", {31'd0, busy}, 32'd1);
        start = 1'b0; in_valid = 1'b1; in_data = 8'h77;
        tick(); check_write("rst.w_new", 8'h00, 8'h77, 1'b1);
        check("rst.count_new", {23'd0, count}, 32'd1);
        in_valid = 1'b0;
        tick();
        check("rst.busy_end", {31'd0, busy}, 32'd0);
        check("rst.wr_en_end", {31'd0, wr_en}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
